sb_trans_id_alloc: RTL
======================

Name: sb_trans_id_alloc

Overview:
- Circular transaction-ID allocator for the scoreboard.
- Hands out trans IDs to the issue ports in program order and retires them in order on commit.
- Parameterised solely by the elaborated config_pkg::cva6_cfg_t; reads NR_SB_ENTRIES, TRANS_ID_BITS, NrIssuePorts and NrCommitPorts from it.
- Sits between decode/issue (consumer of IDs) and commit (releaser of IDs).

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, elaborated core config (output of build_config).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all outstanding IDs
- alloc_req_i  in  NrIssuePorts  per-port allocation request; port 0 is oldest
- alloc_gnt_o  out  NrIssuePorts  per-port grant, combinational
- alloc_id_o  out  NrIssuePorts x TRANS_ID_BITS  ID offered to each port
- commit_ack_i  in  NrCommitPorts  retire the oldest k IDs
- commit_id_o  out  NrCommitPorts x TRANS_ID_BITS  IDs of the oldest outstanding entries
- commit_valid_o  out  NrCommitPorts  commit_id_o[k] is outstanding
- count_o  out  TRANS_ID_BITS+1  outstanding IDs, registered
- full_o  out  1  count_o == NR_SB_ENTRIES
- empty_o  out  1  count_o == 0

Behaviour:
- Reset is synchronous: on rst_i the issue pointer, commit pointer and count are 0 the following cycle. full_o=0, empty_o=1, all valids/grants=0 while count=0 and there are no requests.
- Clocking: one clock (clk_i); synchronous active-high reset (rst_i). All state updates on the rising edge of clk_i.
- Pointer wrap: pointers wrap modulo NR_SB_ENTRIES, which need not be a power of two. Increment uses compare-and-subtract, never bit truncation.
- alloc_id_o[k] = (issue_ptr + k) mod NR_SB_ENTRIES, whatever the request state.
- Grant rule: alloc_gnt_o[k] = alloc_req_i[k] & gnt[k-1] & (count + k < NR_SB_ENTRIES) & ~flush_i.
  - Grants are in order; a gap ends granting.
  - Space is computed from the registered count only. IDs freed this cycle become allocatable next cycle, so there is no comb path from commit_ack_i to alloc_gnt_o.
- commit_id_o[k] = (commit_ptr + k) mod NR_SB_ENTRIES; commit_valid_o[k] = (k < count).
- Commit retires the contiguous prefix of commit_ack_i that is also valid.
  - An ack on port k without port k-1 is a protocol error: flagged by assertion, only the prefix is counted.
  - Acks on invalid slots are ignored.
- Next-state:
  - issue_ptr += n_alloc
  - commit_ptr += n_commit
  - count += n_alloc - n_commit
  - Simultaneous alloc and commit is legal in the same cycle.
- Flush:
  - All pointers and count go to 0 next cycle.
  - Flush overrides same-cycle alloc and commit.
  - Grants are 0 in the flush cycle.
- Reset has priority over flush.
- Invariant: count <= NR_SB_ENTRIES, checked by assertion.

Optional Feature:
- SB_TRANS_ID_ALLOC_STATS_EN defined:
  - Adds outputs hwm_o (TRANS_ID_BITS+1, peak count since reset) and stall_cnt_o (32-bit, saturating).
  - stall_cnt_o counts cycles in which alloc_req_i[0]=1 and alloc_gnt_o[0]=0 and flush_i=0.
  - Both counters are cleared by rst_i only; flush does not clear them.
- Not defined: neither port nor its logic exists.

Decomposition:
- Package sb_alloc_pkg:
  - function wrap_add(ptr, inc, N): modulo increment.
  - function prefix_count(vec): length of the contiguous-ones prefix.
  - typedef of the stats struct.
- Sub-module sb_ptr_wrap: one wrapping pointer register with sync reset, clear and increment-by-n. Instantiated twice.

Test Plan (NR_SB_ENTRIES=8, NrIssuePorts=2, NrCommitPorts=2):
- Reset, then req=11 with no commits for 4 cycles -> IDs (0,1),(2,3),(4,5),(6,7) granted; full_o=1, count_o=8; next req=11 -> gnt=00.
- From full, ack=11 with req=11 in the same cycle -> gnt=00 that cycle; next cycle count_o=6, gnt=11, ids (0,1) (wrap-around).
- count_o=7, req=11 -> gnt=01, only ID issue_ptr allocated; count_o=8.
- req=10 (port 1 only) -> gnt=00; ack=10 with count_o=3 -> assertion fires, count unchanged.
- count_o=5, flush_i=1 with req=11 and ack=11 -> gnt=00; next cycle count_o=0, empty_o=1, alloc_id_o[0]=0.
- With the macro defined: fill to 6, drain, fill to 3 -> hwm_o=6; hold req=01 while full for 10 cycles -> stall_cnt_o=10; flush -> both counters unchanged.

Source files
------------

// File: rtl/config_pkg.sv
// Minimal elaborated core configuration consumed by the scoreboard ID allocator.
package config_pkg;

  typedef struct packed {
    int unsigned NR_SB_ENTRIES;
    int unsigned TRANS_ID_BITS;
    int unsigned NrIssuePorts;
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  // Standalone defaults so the allocator elaborates without a full core build.
  localparam cva6_cfg_t cva6_cfg_empty = '{
    NR_SB_ENTRIES: 8,
    TRANS_ID_BITS: 3,
    NrIssuePorts:  2,
    NrCommitPorts: 2
  };

endpackage

// File: rtl/sb_alloc_pkg.sv
// Shared helpers and types for the scoreboard transaction-ID allocator.
package sb_alloc_pkg;

  localparam int unsigned PrefixW   = 32;
  localparam int unsigned StallCntW = 32;
  localparam int unsigned HwmMaxW   = 16;

  typedef struct packed {
    logic [HwmMaxW-1:0]   hwm;
    logic [StallCntW-1:0] stall_cnt;
  } sb_stats_t;

  // Modulo increment for non power-of-two rings; requires ptr < n and inc <= n.
  function automatic int unsigned wrap_add(int unsigned ptr, int unsigned inc, int unsigned n);
    int unsigned sum;
    sum = ptr + inc;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

  function automatic int unsigned prefix_count(logic [PrefixW-1:0] vec);
    int unsigned cnt;
    logic        run;
    cnt = 0;
    run = 1'b1;
    for (int i = 0; i < PrefixW; i++) begin
      run = run & vec[i];
      cnt = cnt + 32'(run);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sb_ptr_wrap.sv
// Wrapping ring pointer with synchronous reset, clear and increment-by-n.
module sb_ptr_wrap
  import sb_alloc_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned PtrW = 3,
  parameter int unsigned IncW = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic [IncW-1:0] inc_i,
  output logic [PtrW-1:0] ptr_o
);

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = PtrW'(wrap_add(32'(ptr_q), 32'(inc_i), N));
    if (clear_i) ptr_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sb_trans_id_alloc.sv
// Circular transaction-ID allocator: in-order issue, in-order commit retirement.
// Optional occupancy/stall statistics when SB_TRANS_ID_ALLOC_STATS_EN is defined.
module sb_trans_id_alloc
  import sb_alloc_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
  input  logic                                                          clk_i,
  input  logic                                                          rst_i,
  input  logic                                                          flush_i,
  input  logic [CVA6Cfg.NrIssuePorts-1:0]                               alloc_req_i,
  output logic [CVA6Cfg.NrIssuePorts-1:0]                               alloc_gnt_o,
  output logic [CVA6Cfg.NrIssuePorts-1:0][CVA6Cfg.TRANS_ID_BITS-1:0]    alloc_id_o,
  input  logic [CVA6Cfg.NrCommitPorts-1:0]                              commit_ack_i,
  output logic [CVA6Cfg.NrCommitPorts-1:0][CVA6Cfg.TRANS_ID_BITS-1:0]   commit_id_o,
  output logic [CVA6Cfg.NrCommitPorts-1:0]                              commit_valid_o,
  output logic [CVA6Cfg.TRANS_ID_BITS:0]                                count_o,
  output logic                                                          full_o,
  output logic                                                          empty_o
`ifdef SB_TRANS_ID_ALLOC_STATS_EN
  ,
  output logic [CVA6Cfg.TRANS_ID_BITS:0]                                hwm_o,
  output logic [StallCntW-1:0]                                          stall_cnt_o
`endif
);

  localparam int unsigned NrEntries = CVA6Cfg.NR_SB_ENTRIES;
  localparam int unsigned IdW       = CVA6Cfg.TRANS_ID_BITS;
  localparam int unsigned NrIss     = CVA6Cfg.NrIssuePorts;
  localparam int unsigned NrCom     = CVA6Cfg.NrCommitPorts;
  localparam int unsigned CntW      = IdW + 1;
  localparam int unsigned IssIncW   = $clog2(NrIss + 1);
  localparam int unsigned ComIncW   = $clog2(NrCom + 1);

  logic [IdW-1:0]     issue_ptr, commit_ptr;
  logic [CntW-1:0]    count_q, count_d;
  logic [NrCom-1:0]   commit_ok;
  logic [IssIncW-1:0] n_alloc;
  logic [ComIncW-1:0] n_commit;

  // Space check uses only the registered count, so commit_ack_i never reaches the grants.
  always_comb begin
    logic run;
    run         = 1'b1;
    alloc_gnt_o = '0;
    for (int k = 0; k < NrIss; k++) begin
      run = run & alloc_req_i[k] & ((32'(count_q) + 32'(k)) < NrEntries) & ~flush_i;
      alloc_gnt_o[k] = run;
    end
  end

  always_comb begin
    alloc_id_o     = '0;
    commit_id_o    = '0;
    commit_valid_o = '0;
    for (int k = 0; k < NrIss; k++) begin
      alloc_id_o[k] = IdW'(wrap_add(32'(issue_ptr), 32'(k), NrEntries));
    end
    for (int k = 0; k < NrCom; k++) begin
      commit_id_o[k]    = IdW'(wrap_add(32'(commit_ptr), 32'(k), NrEntries));
      commit_valid_o[k] = 32'(count_q) > 32'(k);
    end
  end

  assign commit_ok = commit_ack_i & commit_valid_o;
  assign n_alloc   = IssIncW'(prefix_count(PrefixW'(alloc_gnt_o)));
  assign n_commit  = ComIncW'(prefix_count(PrefixW'(commit_ok)));

  always_comb begin
    count_d = CntW'(32'(count_q) + 32'(n_alloc) - 32'(n_commit));
    if (flush_i) count_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  sb_ptr_wrap #(
    .N    (NrEntries),
    .PtrW (IdW),
    .IncW (IssIncW)
  ) u_issue_ptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .inc_i   (n_alloc),
    .ptr_o   (issue_ptr)
  );

  sb_ptr_wrap #(
    .N    (NrEntries),
    .PtrW (IdW),
    .IncW (ComIncW)
  ) u_commit_ptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .inc_i   (n_commit),
    .ptr_o   (commit_ptr)
  );

  assign count_o = count_q;
  assign full_o  = 32'(count_q) == NrEntries;
  assign empty_o = count_q == '0;

`ifdef SB_TRANS_ID_ALLOC_STATS_EN
  sb_stats_t stats_q, stats_d;

  // Peak tracks the registered count; stall counter saturates at all-ones.
  always_comb begin
    stats_d = stats_q;
    if (HwmMaxW'(count_q) > stats_q.hwm) stats_d.hwm = HwmMaxW'(count_q);
    if (alloc_req_i[0] & ~alloc_gnt_o[0] & ~flush_i & (stats_q.stall_cnt != '1)) begin
      stats_d.stall_cnt = stats_q.stall_cnt + StallCntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stats_q <= '0;
    else       stats_q <= stats_d;
  end

  assign hwm_o       = stats_q.hwm[CntW-1:0];
  assign stall_cnt_o = stats_q.stall_cnt;
`endif

  count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(count_q) <= NrEntries)
    else $error("sb_trans_id_alloc: count exceeds NR_SB_ENTRIES");

  // A gap in the ack vector is a commit-side protocol error; only the prefix retires.
  ack_contiguous: assert property (@(posedge clk_i) disable iff (rst_i)
    32'($countones(commit_ack_i)) == prefix_count(PrefixW'(commit_ack_i)))
    else $warning("sb_trans_id_alloc: commit_ack_i has a gap (%b)", commit_ack_i);

endmodule
